// File: rtl/tone_sequencer_if.sv
// Control and status bundle between the user-input block and the tone sequencer.
// The master side (switch/key logic) drives playback control and step-memory
// writes; the slave side (the sequencer) returns the divider settings and status.
interface tone_sequencer_if;
  logic        start;
  logic        stop;
  logic        loop;
  logic [4:0]  seq_len;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [31:0] div_clk_count;
  logic        tone_en;
  logic        busy;
  logic        done;
  logic [3:0]  step_idx;

  modport master (
    output start, stop, loop, seq_len, wr_en, wr_addr, wr_data,
    input  div_clk_count, tone_en, busy, done, step_idx
  );

  modport slave (
    input  start, stop, loop, seq_len, wr_en, wr_addr, wr_data,
    output div_clk_count, tone_en, busy, done, step_idx
  );
endinterface

// File: rtl/tone_sequencer.sv
// Tone sequencer: steps through up to 16 programmed notes/rests, holding each
// for NOTE_TICKS cycles followed by GAP_TICKS silent cycles, and drives the
// divide count and enable of the downstream audio clock divider.
module tone_sequencer #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned NOTE_TICKS = 25_000_000,
  parameter int unsigned GAP_TICKS  = 2_500_000
) (
  input logic              inclk,
  input logic              Reset,
  tone_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NOTE,
    S_GAP
  } state_t;

  // What the output stage must do on the coming edge.
  typedef enum logic [2:0] {
    ACT_HOLD,   // keep outputs, done low
    ACT_LOAD,   // load the entry at the next step index and mark busy
    ACT_MUTE,   // tone finished, gap begins
    ACT_DONE,   // normal completion (or empty sequence)
    ACT_ABORT   // stopped by the user
  } action_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_TICKS == 0) ? 32'd0 : 32'(GAP_TICKS - 1);
  localparam bit          HAS_GAP   = (GAP_TICKS != 0);
  localparam logic [4:0]  MAX_LEN   = 5'd16;

  // Half-period divide count for each note code (Do..Do'), truncated.
  function automatic logic [31:0] note_div(input logic [2:0] code);
    case (code)
      3'd0:    note_div = 32'(CLK_HZ / (2 * 523));
      3'd1:    note_div = 32'(CLK_HZ / (2 * 587));
      3'd2:    note_div = 32'(CLK_HZ / (2 * 659));
      3'd3:    note_div = 32'(CLK_HZ / (2 * 698));
      3'd4:    note_div = 32'(CLK_HZ / (2 * 783));
      3'd5:    note_div = 32'(CLK_HZ / (2 * 880));
      3'd6:    note_div = 32'(CLK_HZ / (2 * 987));
      default: note_div = 32'(CLK_HZ / (2 * 1046));
    endcase
  endfunction

  // Registered state and outputs
  state_t      r_state;
  logic [31:0] r_tick;
  logic [3:0]  r_step;
  logic [4:0]  r_len;
  logic [31:0] r_div;
  logic        r_tone;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_mem [16];

  // Next-state / next-output values
  state_t      w_state_nxt;
  logic [31:0] w_tick_nxt;
  logic [3:0]  w_step_nxt;
  logic [4:0]  w_len_nxt;
  action_t     w_act;
  logic [31:0] w_div_nxt;
  logic        w_tone_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  // Decoded helpers
  logic [4:0]  w_len_clamped;
  logic        w_last_step;
  logic        w_note_end;
  logic        w_step_end;
  logic        w_wr_commit;
  logic [3:0]  w_entry;

  assign w_len_clamped = (bus.seq_len > MAX_LEN) ? MAX_LEN : bus.seq_len;
  assign w_last_step   = ({1'b0, r_step} + 5'd1) >= r_len;
  assign w_note_end    = (r_state == S_NOTE) && (r_tick == NOTE_LAST);
  // With no gap configured, the end of the tone is also the end of the step.
  assign w_step_end    = (w_note_end && !HAS_GAP) ||
                         ((r_state == S_GAP) && (r_tick == GAP_LAST));
  // Programming is only allowed while idle and not being told to start.
  assign w_wr_commit   = (r_state == S_IDLE) && bus.wr_en && !bus.start;
  // Entry that an ACT_LOAD will play: the step index being moved to.
  assign w_entry       = r_mem[w_step_nxt];

  // State register: sequencing state, tick counter and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_step  <= '0;
      r_len   <= '0;
      r_div   <= '0;
      r_tone  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_step  <= w_step_nxt;
      r_len   <= w_len_nxt;
      r_div   <= w_div_nxt;
      r_tone  <= w_tone_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Step memory: 16 x {rest, code}, written from the user side while idle.
  // NOTE: the step memory is built from flops with an async clear because a
  // reset must leave every step reading as code 0; a RAM could not do that.
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (w_wr_commit) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Next-state logic: state transitions, tick/step bookkeeping and the action
  // handed to the output stage.
  // NOTE: every signal gets a default at the top of the block so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick + 32'd1;
    w_step_nxt  = r_step;
    w_len_nxt   = r_len;
    w_act       = ACT_HOLD;

    case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        if (bus.start) begin
          if (w_len_clamped != 5'd0) begin
            w_state_nxt = S_NOTE;
            w_step_nxt  = '0;
            w_len_nxt   = w_len_clamped;
            w_act       = ACT_LOAD;
          end else begin
            w_act = ACT_DONE;
          end
        end
      end

      S_NOTE, S_GAP: begin
        if (bus.stop) begin
          // Stop outranks both step advance and completion.
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_step_nxt  = '0;
          w_act       = ACT_ABORT;
        end else if (w_step_end) begin
          w_tick_nxt = '0;
          if (!w_last_step) begin
            w_state_nxt = S_NOTE;
            w_step_nxt  = r_step + 4'd1;
            w_act       = ACT_LOAD;
          end else if (bus.loop) begin
            w_state_nxt = S_NOTE;
            w_step_nxt  = '0;
            w_act       = ACT_LOAD;
          end else begin
            // step_idx keeps pointing at the last step played.
            w_state_nxt = S_IDLE;
            w_act       = ACT_DONE;
          end
        end else if (w_note_end) begin
          w_state_nxt = S_GAP;
          w_tick_nxt  = '0;
          w_act       = ACT_MUTE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_tick_nxt  = '0;
      end
    endcase
  end

  // Output logic: translate the chosen action into next output values.
  // A rest leaves the divide count untouched so the divider does not glitch.
  always_comb begin
    w_div_nxt  = r_div;
    w_tone_nxt = r_tone;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;

    case (w_act)
      ACT_LOAD: begin
        w_busy_nxt = 1'b1;
        if (!w_entry[3]) begin
          w_div_nxt  = note_div(w_entry[2:0]);
          w_tone_nxt = 1'b1;
        end else begin
          w_tone_nxt = 1'b0;
        end
      end
      ACT_MUTE: begin
        w_tone_nxt = 1'b0;
      end
      ACT_DONE: begin
        w_tone_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      ACT_ABORT: begin
        w_tone_nxt = 1'b0;
        w_busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.div_clk_count = r_div;
  assign bus.tone_en       = r_tone;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.step_idx      = r_step;

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Plays a programmed sequence of up to 16 notes by driving the divide count and enable of the audio clock divider. Each step holds one note, or a rest, for a fixed number of clock ticks, followed by a silent gap. Supports single-shot and loop playback, with a start/stop/done handshake toward the top-level switch/key logic. Sits between the user-input block and the clock divider: div_clk_count feeds the divider, and tone_en gates its output.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; note table entry = CLK_HZ/(2*f_note), truncated to an integer
NOTE_TICKS, 25_000_000, clock cycles a step's tone is held (must be >=1)
GAP_TICKS, 2_500_000, silent cycles after each step (0 = no gap)

Ports:
inclk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
start  in  1  begin playback (level, sampled in IDLE)
stop  in  1  abort playback
loop  in  1  1 = repeat sequence after last step
seq_len  in  5  number of steps to play, 0..31 (clamped to 16)
wr_en  in  1  step-memory write strobe
wr_addr  in  4  step index to write
wr_data  in  4  [3]=rest flag, [2:0]=note code
div_clk_count  out  32  divide count to the clock divider
tone_en  out  1  1 while a non-rest note is sounding
busy  out  1  1 while playing
done  out  1  1-cycle pulse on normal completion
step_idx  out  4  current step

Behaviour:
- Reset low (async): state=IDLE; div_clk_count=0, tone_en=0, busy=0, done=0, step_idx=0; all 16 memory entries cleared to 0; tick counter=0.
- Note table at default CLK_HZ, codes 0..7: 47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900 (Do..Do' = 523, 587, 659, 698, 783, 880, 987, 1046 Hz).
- States: IDLE, NOTE, GAP. All outputs are registered. done defaults to 0 every cycle.
- IDLE, start=1, clamped len L>=1: at the edge, state=NOTE, step_idx=0, latch L, tick=0, busy=1.
  - Non-rest entry: div_clk_count=table[code], tone_en=1.
  - Rest entry: div_clk_count holds its value, tone_en=0.
- IDLE, start=1, L=0: stay IDLE; done=1 for one cycle; busy stays 0.
- NOTE: tick increments each cycle. When tick==NOTE_TICKS-1: tick=0, tone_en=0, state=GAP. If GAP_TICKS=0, apply the end-of-gap action directly instead.
- End of gap (tick==GAP_TICKS-1):
  - step_idx<L-1: step_idx+1, load the next entry as in IDLE, state=NOTE.
  - Last step, loop=1 (sampled at this edge): step_idx=0, load entry 0, state=NOTE.
  - Last step, loop=0: state=IDLE, busy=0, done=1, tone_en=0.
- Step period = NOTE_TICKS+GAP_TICKS cycles. tone_en rises on the same edge that loads div_clk_count.
- stop=1 in NOTE or GAP: next edge forces IDLE, tone_en=0, busy=0, done=0, step_idx=0. stop has priority over step advance and completion. stop in IDLE has no effect.
- start while busy is ignored. Playback restarts only from IDLE.
- Writes commit only in IDLE with start=0. If start and wr_en are asserted in the same cycle, the write is dropped. Writes while busy are dropped.
- seq_len is sampled only at start; changes during playback have no effect.
- Tick counter is 32-bit with no wrap: it is always cleared at each state change.

Test Plan:
(All with NOTE_TICKS=4, GAP_TICKS=2.)
1. Write mem0=2, mem1=8, mem2=7; seq_len=3, loop=0; pulse start at edge E0.
   - Edges E0..E5: div=37936, tone_en high for 4 cycles then low 2.
   - Edges E6..E11: tone_en=0, div stays 37936.
   - Edge E12: div=23900, tone_en=1.
   - Edge E18: done=1 for one cycle, busy=0.
2. seq_len=2, loop=1 -> step_idx sequence 0,1,0,1 at 6-cycle spacing with no done. stop asserted mid-NOTE -> next edge: tone_en=0, busy=0, step_idx=0, done=0.
3. seq_len=0 with start -> done pulse one cycle later, busy never rises. seq_len=20 -> exactly 16 steps played, done at E0+96.
4. wr_en to addr 5 while busy -> memory unchanged. start+wr_en in the same IDLE cycle -> write dropped, playback starts. start held while busy -> no restart.
5. Drive Reset low mid-GAP, asynchronously between edges -> all outputs 0 immediately and memory reads 0. After Reset goes high, start plays code 0 (47801).
6. GAP_TICKS=0 build -> steps back-to-back every 4 cycles, with tone_en continuously high across consecutive non-rest steps.
